// File: rtl/ppi_strobe_source_if.sv
// Producer and PPI-port signal bundle for ppi_strobe_source.
// The design uses the slave modport; the producer / PPI side uses master.
interface ppi_strobe_source_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    port_data;
    logic          port_oe;
    logic          stbb;
    logic          ibf;
    logic          busy;

    modport master (
        output wr_en, wr_data, ibf,
        input  full, empty, count, overflow, port_data, port_oe, stbb, busy
    );

    modport slave (
        input  wr_en, wr_data, ibf,
        output full, empty, count, overflow, port_data, port_oe, stbb, busy
    );
endinterface

// File: rtl/ppi_strobe_source.sv
// Buffers producer bytes and strobes them into a PPI Mode 1 input port,
// pacing each byte on the PPI's IBF flag (latched, then read by the CPU).
module ppi_strobe_source #(
    parameter int DEPTH        = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int STB_CYCLES   = 4
) (
    input  logic                clk,
    input  logic                reset,
    ppi_strobe_source_if.slave  bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int TMAX = (SETUP_CYCLES > STB_CYCLES) ? SETUP_CYCLES : STB_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_STROBE   = 3'd2;
    localparam logic [2:0] S_HOLD     = 3'd3;
    localparam logic [2:0] S_WAIT_SET = 3'd4;
    localparam logic [2:0] S_WAIT_CLR = 3'd5;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          stbb_q, stbb_d;
    logic          oe_q, oe_d;
    logic [7:0]    data_q, data_d;
    logic          ibf_meta_q, ibf_s_q;

    logic full, empty, push, pop;

    // full is taken from the registered count, so a same-cycle pop never frees a slot for the push
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.wr_en && !full;
    assign pop   = (state_q == S_IDLE) && !empty && !ibf_s_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        stbb_d  = stbb_q;
        oe_d    = oe_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    data_d  = mem_q[rd_ptr_q];
                    oe_d    = 1'b1;
                    timer_d = TW'(SETUP_CYCLES - 1);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (timer_q == '0) begin
                    stbb_d  = 1'b0;
                    timer_d = TW'(STB_CYCLES - 1);
                    state_d = S_STROBE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_STROBE: begin
                if (timer_q == '0) begin
                    stbb_d  = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_HOLD: begin
                oe_d    = 1'b0;
                state_d = S_WAIT_SET;
            end
            S_WAIT_SET: if (ibf_s_q)  state_d = S_WAIT_CLR;
            S_WAIT_CLR: if (!ibf_s_q) state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                stbb_d  = 1'b1;
                oe_d    = 1'b0;
            end
        endcase
    end

    // NOTE: the byte store carries no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            stbb_q     <= 1'b1;
            oe_q       <= 1'b0;
            data_q     <= 8'h00;
            ibf_meta_q <= 1'b0;
            ibf_s_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (bus.wr_en && full) overflow_q <= 1'b1;
            count_q    <= count_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            stbb_q     <= stbb_d;
            oe_q       <= oe_d;
            data_q     <= data_d;
            ibf_meta_q <= bus.ibf;
            ibf_s_q    <= ibf_meta_q;
        end
    end

    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.port_data = data_q;
    assign bus.port_oe   = oe_q;
    assign bus.stbb      = stbb_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule
